// File: rtl/iram_wb_target.sv
// Wishbone target for the 512x16 internal RAM: single, 4-beat and 8-beat wrapping bursts.
// Partial-select writes merge the new bytes with the RAM read data of the same word.
`ifndef WB_ADDR_W
`define WB_ADDR_W 16
`endif

module iram_wb_target #(
  parameter int unsigned        ADDR_W = `WB_ADDR_W,
  parameter logic [ADDR_W-10:0] BASE   = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wb_cyc,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_adr,
  input  logic [15:0]       wb_i_dat,
  input  logic [1:0]        wb_sel,
  input  logic              wb_4_burst,
  input  logic              wb_8_burst,
  output logic [15:0]       wb_o_dat,
  output logic              wb_ack,
  output logic              wb_err,
  output logic [8:0]        ram_addr,
  output logic [15:0]       ram_o_data,
  input  logic [15:0]       ram_i_data,
  output logic              ram_we
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Beat k of a burst; mask selects the low address bits that wrap (000, 011 or 111).
  function automatic logic [8:0] beat_addr(input logic [8:0] base,
                                           input logic [2:0] mask,
                                           input logic [2:0] k);
    logic [2:0] low;
    low = base[2:0] + k;
    return {base[8:3], (base[2:0] & ~mask) | (low & mask)};
  endfunction

  function automatic logic [15:0] byte_merge(input logic [1:0]  sel,
                                             input logic [15:0] new_dat,
                                             input logic [15:0] old_dat);
    return {sel[1] ? new_dat[15:8] : old_dat[15:8],
            sel[0] ? new_dat[7:0]  : old_dat[7:0]};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [8:0]  base_r;
  logic [1:0]  sel_r;
  logic [2:0]  mask_r;
  logic [2:0]  beat_r;
  logic        req_s;
  logic        hit_s;
  logic        last_s;
  logic        burst_s;

  assign req_s   = wb_cyc & wb_stb;
  assign hit_s   = (wb_adr[ADDR_W-1:9] == BASE);
  assign last_s  = (beat_r == mask_r);
  assign burst_s = wb_4_burst | wb_8_burst;

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (!hit_s) begin
            state_s = ERR;
          end else if (wb_we) begin
            state_s = WR;
          end else begin
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD, WR: begin
        if (!wb_cyc || last_s) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture at acceptance; bursts always write whole words
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      base_r <= 9'd0;
      sel_r  <= 2'b00;
      mask_r <= 3'b000;
    end else if (state_r == IDLE && req_s) begin
      base_r <= wb_adr[8:0];
      sel_r  <= burst_s ? 2'b11 : wb_sel;
      mask_r <= wb_8_burst ? 3'b111 : (wb_4_burst ? 3'b011 : 3'b000);
    end else begin
      base_r <= base_r;
      sel_r  <= sel_r;
      mask_r <= mask_r;
    end
  end

  // Beat counter: one step per acknowledged beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_r <= 3'd0;
    end else if (state_r == IDLE) begin
      beat_r <= 3'd0;
    end else if ((state_r == RD || state_r == WR) && wb_cyc) begin
      beat_r <= beat_r + 3'd1;
    end else begin
      beat_r <= beat_r;
    end
  end

  // Bus and RAM outputs; reads run one address ahead because the RAM has one cycle of latency
  always_comb begin
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_o_dat   = 16'h0000;
    ram_we     = 1'b0;
    ram_addr   = wb_adr[8:0];
    ram_o_data = 16'h0000;
    case (state_r)
      IDLE: ram_addr = wb_adr[8:0];
      RD: begin
        wb_ack   = wb_cyc;
        wb_o_dat = wb_cyc ? ram_i_data : 16'h0000;
        ram_addr = beat_addr(base_r, mask_r, beat_r + 3'd1);
      end
      WR: begin
        wb_ack     = wb_cyc;
        ram_we     = wb_cyc & wb_stb;
        ram_addr   = beat_addr(base_r, mask_r, beat_r);
        ram_o_data = byte_merge(sel_r, wb_i_dat, ram_i_data);
      end
      ERR: begin
        wb_err   = 1'b1;
        ram_addr = base_r;
      end
      default: ram_addr = wb_adr[8:0];
    endcase
  end

endmodule

// File: tb/tb_iram_wb_target.sv
// Self-checking bench for iram_wb_target: directed plan plus random transactions
// checked against a word-array model of the RAM.
`timescale 1ns/1ps
module tb_iram_wb_target;
  localparam int AW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          wb_cyc, wb_stb, wb_we, wb_4_burst, wb_8_burst;
  logic [AW-1:0] wb_adr;
  logic [15:0]   wb_i_dat, wb_o_dat, ram_o_data, ram_i_data;
  logic [1:0]    wb_sel;
  logic          wb_ack, wb_err, ram_we;
  logic [8:0]    ram_addr;

  logic [15:0] ram_mem [512];
  logic [15:0] model [512];
  logic [15:0] wbuf [8];
  logic        pre_en = 1'b0;
  logic [8:0]  pre_addr = 9'd0;
  logic [15:0] pre_dat = 16'h0000;
  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int overlap_cnt = 0;

  always #5 i_clk = ~i_clk;

  iram_wb_target #(.ADDR_W(AW), .BASE(7'd0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_i_dat(wb_i_dat), .wb_sel(wb_sel), .wb_4_burst(wb_4_burst),
    .wb_8_burst(wb_8_burst), .wb_o_dat(wb_o_dat), .wb_ack(wb_ack), .wb_err(wb_err),
    .ram_addr(ram_addr), .ram_o_data(ram_o_data), .ram_i_data(ram_i_data), .ram_we(ram_we)
  );

  // Synchronous-read RAM with a bench-side preload port
  always @(posedge i_clk) begin
    if (pre_en) ram_mem[pre_addr] <= pre_dat;
    else if (ram_we) ram_mem[ram_addr] <= ram_o_data;
    ram_i_data <= ram_mem[ram_addr];
  end

  always @(negedge i_clk) begin
    if (ram_we === 1'b1) we_cnt++;
    if (wb_ack === 1'b1 && wb_err === 1'b1) overlap_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int base, input int n, input int k);
    return (base / n) * n + ((base % n) + k) % n;
  endfunction

  task automatic idle_inputs();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 2'b00;
    wb_4_burst = 1'b0; wb_8_burst = 1'b0; wb_i_dat = 16'h0000;
  endtask

  task automatic preload(input int a, input logic [15:0] d);
    @(posedge i_clk); #1;
    pre_en = 1'b1; pre_addr = 9'(a); pre_dat = d;
    @(posedge i_clk); #1;
    pre_en = 1'b0;
    model[a] = d;
  endtask

  // One transaction; stop_after < n drops wb_cyc after that many acks
  task automatic xfer(input bit we, input logic [15:0] adr, input logic [1:0] sel,
                      input int n, input int stop_after, input string tag);
    int base, a, done;
    logic [15:0] m;
    base = int'(adr[8:0]);
    done = 0;
    @(posedge i_clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel;
    wb_4_burst = (n == 4); wb_8_burst = (n == 8); wb_i_dat = wbuf[0];
    #1 chk1({tag, "/pre_ack"}, wb_ack, 1'b0);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk); #1;
      wb_4_burst = 1'b0; wb_8_burst = 1'b0;
      wb_i_dat = wbuf[k];
      if (k == stop_after) begin
        wb_cyc = 1'b0; wb_stb = 1'b0;
      end
      #1;
      a = exp_addr(base, n, k);
      if (k == stop_after) begin
        chk1({tag, "/abort_ack"}, wb_ack, 1'b0);
        chk1({tag, "/abort_we"}, ram_we, 1'b0);
        chk16({tag, "/abort_dat"}, wb_o_dat, 16'h0000);
        break;
      end
      chk1({tag, "/ack"}, wb_ack, 1'b1);
      chk1({tag, "/err"}, wb_err, 1'b0);
      if (we) begin
        chk1({tag, "/ram_we"}, ram_we, 1'b1);
        m = model[a];
        if (n == 1) model[a] = {sel[1] ? wbuf[k][15:8] : m[15:8], sel[0] ? wbuf[k][7:0] : m[7:0]};
        else model[a] = wbuf[k];
      end else begin
        chk16({tag, "/rdata"}, wb_o_dat, model[a]);
      end
      done++;
    end
    @(posedge i_clk); #1;
    idle_inputs();
    #1 chk1({tag, "/end_ack"}, wb_ack, 1'b0);
    if (we) begin
      for (int k = 0; k < n; k++) begin
        a = exp_addr(base, n, k);
        chk16({tag, "/mem"}, ram_mem[a], model[a]);
      end
    end
  endtask

  task automatic miss(input bit we, input logic [15:0] adr, input int n, input string tag);
    int w0;
    w0 = we_cnt;
    @(posedge i_clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = 2'b11;
    wb_4_burst = (n == 4); wb_8_burst = (n == 8); wb_i_dat = 16'hDEAD;
    #1 chk1({tag, "/pre_err"}, wb_err, 1'b0);
    @(posedge i_clk); #1;
    idle_inputs();
    #1;
    chk1({tag, "/err"}, wb_err, 1'b1);
    chk1({tag, "/ack"}, wb_ack, 1'b0);
    @(posedge i_clk); #2;
    chk1({tag, "/err_gone"}, wb_err, 1'b0);
    chk1({tag, "/no_ack"}, wb_ack, 1'b0);
    chk_int({tag, "/no_we"}, we_cnt, w0);
    for (int k = 0; k < 8; k++) chk16({tag, "/mem"}, ram_mem[k], model[k]);
  endtask

  initial begin
    int n, stop;
    logic we;
    i_rst = 1'b1;
    idle_inputs();
    wb_adr = 16'h01A5;
    #12;
    chk1("rst/ack", wb_ack, 1'b0);
    chk1("rst/err", wb_err, 1'b0);
    chk1("rst/we", ram_we, 1'b0);
    chk16("rst/odat", wb_o_dat, 16'h0000);
    chk16("rst/addr", {7'd0, ram_addr}, 16'h01A5);
    @(posedge i_clk); #1 i_rst = 1'b0;

    for (int i = 0; i < 512; i++) begin
      @(posedge i_clk); #1;
      pre_en = 1'b1; pre_addr = 9'(i); pre_dat = 16'($urandom);
      model[i] = pre_dat;
    end
    @(posedge i_clk); #1 pre_en = 1'b0;

    wbuf[0] = 16'hBEEF; xfer(1'b1, 16'h0005, 2'b11, 1, 99, "wr_full");
    chk16("wr_full/const", ram_mem[5], 16'hBEEF);
    xfer(1'b0, 16'h0005, 2'b11, 1, 99, "rd_full");
    wbuf[0] = 16'h1234; xfer(1'b1, 16'h0005, 2'b01, 1, 99, "wr_lo");
    chk16("wr_lo/const", ram_mem[5], 16'hBE34);
    wbuf[0] = 16'hAA00; xfer(1'b1, 16'h0005, 2'b10, 1, 99, "wr_hi");
    chk16("wr_hi/const", ram_mem[5], 16'hAA34);

    for (int i = 0; i < 8; i++) preload(16 + i, 16'(i));
    xfer(1'b0, 16'h0016, 2'b11, 8, 99, "rd8_wrap");

    for (int i = 0; i < 4; i++) wbuf[i] = 16'(10 + i);
    xfer(1'b1, 16'h00A2, 2'b00, 4, 99, "wr4");
    chk16("wr4/a2", ram_mem[9'h0A2], 16'h000A);
    chk16("wr4/a3", ram_mem[9'h0A3], 16'h000B);
    chk16("wr4/a0", ram_mem[9'h0A0], 16'h000C);
    chk16("wr4/a1", ram_mem[9'h0A1], 16'h000D);
    for (int i = 0; i < 4; i++) wbuf[i] = 16'h1111 * 16'(i + 1);
    xfer(1'b1, 16'h00A2, 2'b11, 4, 2, "wr4_abort");
    chk16("wr4_abort/a2", ram_mem[9'h0A2], 16'h1111);
    chk16("wr4_abort/a3", ram_mem[9'h0A3], 16'h2222);
    chk16("wr4_abort/a0", ram_mem[9'h0A0], 16'h000C);
    chk16("wr4_abort/a1", ram_mem[9'h0A1], 16'h000D);

    miss(1'b0, 16'h0200, 1, "miss_rd");
    miss(1'b1, 16'h0200, 1, "miss_wr");
    miss(1'b0, 16'h0200, 8, "miss_b8");

    @(posedge i_clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 16'h0016; wb_8_burst = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    chk1("rstmid/ack_before", wb_ack, 1'b1);
    chk16("rstmid/beat3", wb_o_dat, model[17]);
    #2 i_rst = 1'b1;
    #1;
    chk1("rstmid/ack", wb_ack, 1'b0);
    chk16("rstmid/odat", wb_o_dat, 16'h0000);
    @(posedge i_clk); #1 idle_inputs();
    @(posedge i_clk); #1 i_rst = 1'b0;
    xfer(1'b0, 16'h0001, 2'b11, 1, 99, "rd_after_rst");

    for (int t = 0; t < 40; t++) begin
      n = ($urandom_range(0, 2) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 4 : 8);
      stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 99;
      we = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
      xfer(we, {7'd0, 9'($urandom_range(0, 511))}, 2'($urandom_range(0, 3)), n, stop, "rand");
    end

    chk_int("no_ack_err_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iram_wb_target.md
# iram_wb_target

Wishbone target that serves the 512×16 internal RAM on the inner bus. It is the responder side of the bus driven by the data cache, the instruction caches and the outer interconnect. It decodes a fixed address window and turns single, 4-beat and 8-beat burst cycles into internal RAM accesses. Partial-select writes are handled by merging with the RAM read data.

## Interface
Parameters:
- `ADDR_W`, default `` `WB_ADDR_W ``: inner bus word-address width.
- `BASE`, default 0: value that `wb_adr[ADDR_W-1:9]` must equal for a hit.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `wb_cyc`, `wb_stb`, `wb_we` in 1 each: Wishbone cycle, strobe and write enable.
- `wb_adr` in ADDR_W: word address.
- `wb_i_dat` in 16: write data from the master.
- `wb_sel` in 2: byte select; bit 1 is the high byte.
- `wb_4_burst`, `wb_8_burst` in 1 each: burst request. Sampled only at acceptance.
- `wb_o_dat` out 16: read data.
- `wb_ack` out 1: beat acknowledge.
- `wb_err` out 1: error response for an address outside the window.
- `ram_addr` out 9: RAM word address. The RAM samples it on the rising edge; read data is valid the following cycle.
- `ram_o_data` out 16: write data to the RAM.
- `ram_i_data` in 16: read data from the RAM.
- `ram_we` out 1: RAM write enable. A write commits at the rising edge.

## Operation
States: IDLE, RD, WR, ERR.
- **Acceptance:** in IDLE, a rising edge with `wb_cyc & wb_stb` accepts a request.
  - Latched: base address `wb_adr[8:0]`, `wb_we`, `wb_sel`, and beat count.
  - Beat count is 8 if `wb_8_burst`, otherwise 4 if `wb_4_burst`, otherwise 1. If both burst flags are high, 8 wins.
  - Next state: ERR on a miss; otherwise RD or WR.
- **IDLE outputs:** `ram_addr = wb_adr[8:0]`, so the RAM reads the request address at the acceptance edge.
- **Beat address:** beat k uses `{base[8:3], (base[2:0]+k) mod 8}` for 8-beat bursts and `{base[8:2], (base[1:0]+k) mod 4}` for 4-beat bursts. It wraps inside the aligned block and never leaves it. Beat address uses a 3-bit counter.
- **RD:**
  - `wb_ack = 1` and `wb_o_dat = ram_i_data` (the data for beat k).
  - `ram_addr` is the address of beat k+1, so one beat completes per cycle.
- **WR:**
  - `wb_ack = 1`, `ram_addr` = beat k address, `ram_we = wb_cyc & wb_stb`.
  - `ram_o_data` per byte: `wb_sel[i] ? wb_i_dat byte i : ram_i_data byte i`. `ram_i_data` is the read of the same address from the previous edge.
  - Bursts force sel = 11.
  - The master holds `wb_i_dat` for beat k during beat k's ack cycle and advances on the edge.
- **After the last beat:** the edge ending the last beat's ack returns the state to IDLE.
- **ERR:**
  - `wb_err = 1` for exactly one cycle, then IDLE.
  - No ack, no RAM write. A burst miss gets one err and is terminated.
- **Master abort:** `wb_cyc` low in RD or WR sends the state to IDLE at the next edge.
  - In that cycle `wb_ack`/`ram_we` are gated to 0 (`ack = state_ack & wb_cyc`).
  - No further beats occur.
- **Output rules when not acking:** `wb_o_dat` is 0 when `wb_ack` is 0. `ram_we` is 0 outside WR.

## Timing
- **Reset** (asynchronous, immediate, including mid-burst):
  - State IDLE, beat counter 0.
  - `wb_ack = 0`, `wb_err = 0`, `ram_we = 0`, `wb_o_dat = 0`; `ram_addr` follows `wb_adr[8:0]`.
- **Latency:** the first ack or err is high in the cycle after the acceptance edge, for reads and for full or partial writes alike.
- **Burst throughput:** one beat per cycle. An N-beat burst holds ack high for N consecutive cycles.
- **Back-to-back requests:** a new request is accepted no earlier than the first edge after returning to IDLE, so there is one dead cycle. A single-transfer master must drop `wb_stb` after ack, or it issues a new request.
- **No overlap:** `wb_ack` and `wb_err` are never high together.

## Test plan
- **Full write then read:** write 0xBEEF to word 0x005, sel 11 → ack 1 cycle after accept, RAM[5] = 0xBEEF. Then read 0x005 → ack next cycle, `wb_o_dat` = 0xBEEF.
- **Partial write:** with RAM[5] = 0xBEEF, write 0x1234 with sel 01 → RAM[5] = 0xBE34. Then sel 10 with 0xAA00 → RAM[5] = 0xAA34. Ack latency is 1 in both cases.
- **8-beat read with wrap:** preload RAM[0x10..0x17] = 0x0..0x7, then 8-beat read at 0x016 → 8 consecutive acks, data 6,7,0,1,2,3,4,5. Then IDLE.
- **4-beat write then abort:** 4-beat write at 0x0A2 with data 0xA..0xD → RAM[0xA2,0xA3,0xA0,0xA1] = 0xA..0xD. Then repeat a 4-beat write, dropping `wb_cyc` after 2 acks → only 2 words written, no third ack.
- **Window miss:** `BASE` = 0, access to `wb_adr` = 0x200 (read, write, and 8-burst) → a single `wb_err` pulse, no ack, `ram_we` never high, RAM unchanged.
- **Reset mid-burst:** assert `i_rst` mid-cycle during beat 3 of an 8-beat read → `wb_ack` = 0 immediately. After release, a single read at 0x001 completes normally with latency 1.
